// File: rtl/pong_pkg.sv
// Shared definitions between the ping_pong game core and the LED board scanner:
// packed game-state layout, board size and scan state encoding.
package pong_pkg;

  localparam int PLOC_W  = 12;
  localparam int P1_HI   = 11;
  localparam int P1_LO   = 9;
  localparam int P2_HI   = 8;
  localparam int P2_LO   = 6;
  localparam int BX_HI   = 5;
  localparam int BX_LO   = 3;
  localparam int BY_HI   = 2;
  localparam int BY_LO   = 0;
  localparam int BOARD_N = 8;

  localparam logic [PLOC_W-1:0] PLOC_DEFAULT = 12'b001001100100;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  // Paddle covers centre-1..centre+1; signed distance so edge rows never wrap.
  function automatic logic paddle_hit(input logic [2:0] centre, input logic [2:0] row);
    logic signed [3:0] d;
    d = signed'({1'b0, row}) - signed'({1'b0, centre});
    return (d >= -4'sd1) && (d <= 4'sd1);
  endfunction

endpackage

// File: rtl/led_matrix_scanner_if.sv
// Game-state input and board pin outputs of the LED matrix scanner.
// slave = scanner side, master = game core / board side.
interface led_matrix_scanner_if;

  logic [pong_pkg::PLOC_W-1:0]  ploc_in;
  logic [pong_pkg::BOARD_N-1:0] ledr;
  logic [pong_pkg::BOARD_N-1:0] ledc;
  logic                         frame_start;

  modport master (output ploc_in, input ledr, ledc, frame_start);
  modport slave  (input ploc_in, output ledr, ledc, frame_start);

endinterface

// File: rtl/led_matrix_scanner_row_mask_gen.sv
// Combinational pixel mask for one board row: paddles in columns 0/7 plus the ball.
// Output bit c = 1 means column c is lit.
module row_mask_gen
  import pong_pkg::*;
(
  input  logic [PLOC_W-1:0]  frame,
  input  logic [2:0]         row,
  input  logic               ball_vis,
  output logic [BOARD_N-1:0] mask
);

  logic p1_hit;
  logic p2_hit;
  logic ball_row;

  assign p1_hit   = paddle_hit(frame[P1_HI:P1_LO], row);
  assign p2_hit   = paddle_hit(frame[P2_HI:P2_LO], row);
  assign ball_row = ball_vis && (row == frame[BY_HI:BY_LO]);

  for (genvar gi = 0; gi < BOARD_N; gi++) begin : g_col
    logic ball_hit;
    assign ball_hit = ball_row && (frame[BX_HI:BX_LO] == 3'(gi));
    if (gi == 0) begin : g_p1
      assign mask[gi] = p1_hit | ball_hit;
    end else if (gi == BOARD_N - 1) begin : g_p2
      assign mask[gi] = p2_hit | ball_hit;
    end else begin : g_mid
      assign mask[gi] = ball_hit;
    end
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed 8x8 LED driver; frame latched on each row 7 -> row 0 wrap.
// Optional ball blinking is built when BALL_BLINK_EN is defined.
module led_matrix_scanner
  import pong_pkg::*;
#(
  parameter int ON_CYCLES    = 8,
  parameter int BLANK_CYCLES = 1,
  parameter int BLINK_FRAMES = 16
) (
  input logic               clkouts,
  input logic               resetb,
  led_matrix_scanner_if.slave bus
);

  localparam int CNT_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  if (ON_CYCLES < 1 || BLANK_CYCLES < 1 || BLINK_FRAMES < 2 || (BLINK_FRAMES % 2) != 0) begin : g_bad_param
    $error("led_matrix_scanner: illegal parameter value");
  end

  scan_state_t        state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [2:0]         row_reg, row_next;
  logic [PLOC_W-1:0]  frame_reg, frame_next;
  logic [BOARD_N-1:0] ledr_reg, ledr_next;
  logic [BOARD_N-1:0] ledc_reg, ledc_next;
  logic               fs_reg, fs_next;
  logic               frame_edge;
  logic               ball_vis_next;
  logic [BOARD_N-1:0] mask_next;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    row_next   = row_reg;
    frame_next = frame_reg;
    fs_next    = 1'b0;
    frame_edge = 1'b0;
    case (state_reg)
      ST_BLANK: begin
        if (cnt_reg == BLANK_LAST) begin
          state_next = ST_DRIVE;
          cnt_next   = '0;
          row_next   = row_reg + 3'd1;
          if (row_reg == 3'd7) begin
            frame_next = bus.ploc_in;
            fs_next    = 1'b1;
            frame_edge = 1'b1;
          end
        end
      end
      ST_DRIVE: begin
        if (cnt_reg == ON_LAST) begin
          state_next = ST_BLANK;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = ST_BLANK;
        cnt_next   = '0;
      end
    endcase
  end

`ifdef BALL_BLINK_EN
  localparam int FC_W = $clog2(BLINK_FRAMES);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);
  localparam logic [FC_W-1:0] FC_HALF = FC_W'(BLINK_FRAMES / 2);

  logic [FC_W-1:0] fcnt_reg, fcnt_next;
  logic            seen_reg, seen_next;

  // The first frame after reset leaves fcnt at 0; later frame starts advance it.
  always_comb begin
    fcnt_next = fcnt_reg;
    seen_next = seen_reg;
    if (frame_edge) begin
      seen_next = 1'b1;
      if (seen_reg) begin
        fcnt_next = (fcnt_reg == FC_LAST) ? '0 : fcnt_reg + 1'b1;
      end
    end
  end

  assign ball_vis_next = (fcnt_next < FC_HALF);

  always_ff @(posedge clkouts) begin
    if (!resetb) begin
      fcnt_reg <= '0;
      seen_reg <= 1'b0;
    end else begin
      fcnt_reg <= fcnt_next;
      seen_reg <= seen_next;
    end
  end
`else
  assign ball_vis_next = 1'b1;
`endif

  row_mask_gen u_mask (
    .frame    (frame_next),
    .row      (row_next),
    .ball_vis (ball_vis_next),
    .mask     (mask_next)
  );

  // Pins are computed from next state so they line up with state_reg/row_reg.
  always_comb begin
    ledr_next = '0;
    ledc_next = '1;
    if (state_next == ST_DRIVE) begin
      ledr_next = BOARD_N'(1) << row_next;
      ledc_next = ~mask_next;
    end
  end

  always_ff @(posedge clkouts) begin
    if (!resetb) begin
      state_reg <= ST_BLANK;
      cnt_reg   <= '0;
      row_reg   <= 3'd7;
      frame_reg <= PLOC_DEFAULT;
      ledr_reg  <= '0;
      ledc_reg  <= '1;
      fs_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      row_reg   <= row_next;
      frame_reg <= frame_next;
      ledr_reg  <= ledr_next;
      ledc_reg  <= ledc_next;
      fs_reg    <= fs_next;
    end
  end

  assign bus.ledr        = ledr_reg;
  assign bus.ledc        = ledc_reg;
  assign bus.frame_start = fs_reg;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner; blink scenario runs when BALL_BLINK_EN is defined.
module tb_led_matrix_scanner;
  import pong_pkg::*;

  logic clkouts = 1'b0;
  logic resetb;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clkouts = ~clkouts;

  led_matrix_scanner_if bus ();

`ifdef BALL_BLINK_EN
  led_matrix_scanner #(.ON_CYCLES(8), .BLANK_CYCLES(1), .BLINK_FRAMES(4)) dut (
`else
  led_matrix_scanner #(.ON_CYCLES(8), .BLANK_CYCLES(1), .BLINK_FRAMES(16)) dut (
`endif
    .clkouts (clkouts),
    .resetb  (resetb),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clkouts);
    #1;
  endtask

  task automatic wait_row(input int r, output bit ok);
    logic [7:0] want;
    want = 8'h01 << r;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.ledr == want) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.frame_start == 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    bus.ploc_in = PLOC_DEFAULT;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (bus.ledr !== 8'h00 || bus.ledc !== 8'hFF || bus.frame_start !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_c%0d: ledr=%h ledc=%h fs=%b, required ledr=00 ledc=FF fs=0",
                 i, bus.ledr, bus.ledc, bus.frame_start);
      end
      $display("reset cycle %0d: ledr=%h ledc=%h fs=%b", i, bus.ledr, bus.ledc, bus.frame_start);
    end
  endtask

  task automatic test_first_frame();
    logic [7:0] exp_c [4] = '{8'h7E, 8'h7E, 8'h7E, 8'hFF};
    int  hold;
    int  blank;
    bit  ok;
    resetb = 1'b1;
    tick();
    n_cmp++;
    if (bus.frame_start !== 1'b1 || bus.ledr !== 8'h01 || bus.ledc !== 8'h7E) begin
      n_bad++;
      $display("FAIL first_row0: fs=%b ledr=%h ledc=%h, required fs=1 ledr=01 ledc=7E",
               bus.frame_start, bus.ledr, bus.ledc);
    end
    $display("first frame row0: fs=%b ledr=%h ledc=%h", bus.frame_start, bus.ledr, bus.ledc);
    hold = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.ledr == 8'h01) hold++;
      else break;
    end
    n_cmp++;
    if (hold != 8) begin
      n_bad++;
      $display("FAIL on_cycles: got %0d, required 8", hold);
    end
    blank = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.ledr != 8'h00 || bus.ledc != 8'hFF) break;
      blank++;
      tick();
    end
    n_cmp++;
    if (blank != 1) begin
      n_bad++;
      $display("FAIL blank_cycles: got %0d, required 1", blank);
    end
    $display("row0 on=%0d blank=%0d", hold, blank);
    for (int r = 1; r < 4; r++) begin
      if (r > 1) begin
        wait_row(r, ok);
      end else begin
        ok = (bus.ledr == 8'h02);
      end
      n_cmp++;
      if (!ok || bus.ledc !== exp_c[r]) begin
        n_bad++;
        $display("FAIL first_row%0d: ledr=%h ledc=%h, required ledc=%h", r, bus.ledr, bus.ledc, exp_c[r]);
      end
      $display("first frame row%0d: ledr=%h ledc=%h", r, bus.ledr, bus.ledc);
    end
  endtask

  task automatic test_latency();
    bit ok;
    bus.ploc_in = 12'b110_110_011_000;
    wait_row(4, ok);
    n_cmp++;
    if (!ok || bus.ledc !== 8'hEF) begin
      n_bad++;
      $display("FAIL old_row4: ledc=%h, required EF", bus.ledc);
    end
    $display("old frame row4: ledc=%h", bus.ledc);
    for (int r = 5; r < 8; r++) begin
      wait_row(r, ok);
      n_cmp++;
      if (!ok || bus.ledc !== 8'hFF) begin
        n_bad++;
        $display("FAIL old_row%0d: ledc=%h, required FF", r, bus.ledc);
      end
      $display("old frame row%0d: ledc=%h", r, bus.ledc);
    end
    wait_fs(ok);
    n_cmp++;
    if (!ok || bus.ledr !== 8'h01 || bus.ledc !== 8'hF7) begin
      n_bad++;
      $display("FAIL new_row0: ok=%b ledr=%h ledc=%h, required ledr=01 ledc=F7", ok, bus.ledr, bus.ledc);
    end
    $display("new frame row0: ledr=%h ledc=%h", bus.ledr, bus.ledc);
    for (int r = 5; r < 8; r++) begin
      wait_row(r, ok);
      n_cmp++;
      if (!ok || bus.ledc !== 8'h7E) begin
        n_bad++;
        $display("FAIL new_row%0d: ledc=%h, required 7E", r, bus.ledc);
      end
      $display("new frame row%0d: ledc=%h", r, bus.ledc);
    end
  endtask

  task automatic test_no_wrap();
    logic [7:0] exp_c [8] = '{8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h7E};
    bit ok;
    bus.ploc_in = 12'b000_111_000_111;
    wait_fs(ok);
    for (int r = 0; r < 8; r++) begin
      if (r > 0) wait_row(r, ok);
      n_cmp++;
      if (!ok || bus.ledc !== exp_c[r]) begin
        n_bad++;
        $display("FAIL edge_row%0d: ledr=%h ledc=%h, required ledc=%h", r, bus.ledr, bus.ledc, exp_c[r]);
      end
      $display("edge frame row%0d: ledr=%h ledc=%h", r, bus.ledr, bus.ledc);
    end
  endtask

  task automatic test_reset_mid_row();
    bit ok;
    wait_row(3, ok);
    tick();
    tick();
    resetb = 1'b0;
    tick();
    n_cmp++;
    if (!ok || bus.ledr !== 8'h00 || bus.ledc !== 8'hFF || bus.frame_start !== 1'b0) begin
      n_bad++;
      $display("FAIL midrow_reset: ledr=%h ledc=%h fs=%b, required 00 FF 0", bus.ledr, bus.ledc, bus.frame_start);
    end
    $display("mid-row reset: ledr=%h ledc=%h", bus.ledr, bus.ledc);
    bus.ploc_in = PLOC_DEFAULT;
    tick();
    resetb = 1'b1;
    tick();
    n_cmp++;
    if (bus.frame_start !== 1'b1 || bus.ledr !== 8'h01 || bus.ledc !== 8'h7E) begin
      n_bad++;
      $display("FAIL restart_row0: fs=%b ledr=%h ledc=%h, required 1 01 7E", bus.frame_start, bus.ledr, bus.ledc);
    end
    $display("restart row0: fs=%b ledr=%h ledc=%h", bus.frame_start, bus.ledr, bus.ledc);
  endtask

`ifdef BALL_BLINK_EN
  task automatic test_blink();
    logic [7:0] exp_c [5] = '{8'hEF, 8'hEF, 8'hFF, 8'hFF, 8'hEF};
    bit ok;
    resetb = 1'b0;
    bus.ploc_in = PLOC_DEFAULT;
    tick();
    tick();
    resetb = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_fs(ok);
      if (ok) wait_row(4, ok);
      n_cmp++;
      if (!ok || bus.ledc !== exp_c[k]) begin
        n_bad++;
        $display("FAIL blink_f%0d: ledc=%h, required %h", k, bus.ledc, exp_c[k]);
      end
      $display("blink frame %0d row4: ledc=%h", k, bus.ledc);
    end
  endtask
`endif

  initial begin
    resetb = 1'b0;
    bus.ploc_in = PLOC_DEFAULT;
    test_reset();
    test_first_frame();
    test_latency();
    test_no_wrap();
    test_reset_mid_row();
`ifdef BALL_BLINK_EN
    test_blink();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
